// File: rtl/wide_to_pixel_unpacker.sv
// wide_to_pixel_unpacker
//   Unpacks ISIZE-bit words from the VDMA read FIFO into OSIZE-bit pixels.
//   Any ISIZE/OSIZE ratio is supported through a bit-level residue buffer.
//   A word flagged with i_last closes the line. Any residue bits left after
//   the last full pixel are emitted once as a byte-masked partial pixel.
//
// Ports
//   clock, rst_n       clock, asynchronous active-low reset
//   ialign             synchronous clear of buffer and state (highest priority)
//   i_valid/i_ready    input word handshake; i_last marks the line's last word
//   idata              input word
//   o_valid/o_ready    pixel handshake (o_fire = o_valid && o_ready)
//   o_data, o_mask     pixel and its valid-byte mask
//   o_last             final pixel of the line
module wide_to_pixel_unpacker #(
  parameter int ISIZE     = 256,
  parameter int OSIZE     = 24,
  parameter int MSB_FIRST = 0,
  parameter int CW        = $clog2(ISIZE + OSIZE) + 1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ialign,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_last,
  input  logic [ISIZE-1:0]   idata,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [OSIZE-1:0]   o_data,
  output logic [OSIZE/8-1:0] o_mask,
  output logic               o_last
);

  localparam int          BW  = ISIZE + OSIZE;
  localparam int unsigned NB  = OSIZE / 8;
  localparam logic [CW-1:0] OSZ = CW'(OSIZE);
  localparam logic [CW-1:0] ISZ = CW'(ISIZE);

  // Bits outside the valid region are kept at zero, so partial pixels
  // come out zero-padded and appends can simply be OR-ed in.
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_pend_q, last_pend_d;

  logic          full;
  logic          o_fire;
  logic          accept;
  logic [CW-1:0] take;
  logic [CW-1:0] rem;
  logic [NB-1:0] lsb_mask, msb_mask;
  int unsigned   nbytes;

  always_comb begin
    full     = (cnt_q >= OSZ);
    o_valid  = full || (last_pend_q && (cnt_q != '0));
    o_last   = last_pend_q && (cnt_q <= OSZ);
    o_data   = (MSB_FIRST != 0) ? buf_q[BW-1 -: OSIZE] : buf_q[OSIZE-1:0];

    nbytes   = (int'(cnt_q) + 7) / 8;
    lsb_mask = '0;
    msb_mask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lsb_mask[i]        = (i < nbytes);
      msb_mask[NB-1-i]   = (i < nbytes);
    end
    o_mask   = full ? '1 : ((MSB_FIRST != 0) ? msb_mask : lsb_mask);

    o_fire   = o_valid && o_ready;
    take     = full ? OSZ : cnt_q;
    rem      = o_fire ? (cnt_q - take) : cnt_q;
    // A pending line end blocks input except in the cycle its final pixel fires.
    i_ready  = (!last_pend_q || (o_fire && o_last)) && (rem < OSZ);
    accept   = i_valid && i_ready;
  end

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    last_pend_d = last_pend_q;

    if (o_fire) begin
      if (o_last) begin
        buf_d       = '0;
        cnt_d       = '0;
        last_pend_d = 1'b0;
      end else begin
        // A non-final fire always has a full pixel available.
        buf_d = (MSB_FIRST != 0) ? (buf_q << OSIZE) : (buf_q >> OSIZE);
        cnt_d = rem;
      end
    end

    if (accept) begin
      if (MSB_FIRST != 0) begin
        buf_d = buf_d | ({idata, {OSIZE{1'b0}}} >> rem);
      end else begin
        buf_d = buf_d | ({{OSIZE{1'b0}}, idata} << rem);
      end
      cnt_d = rem + ISZ;
      if (i_last) begin
        last_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
    end else if (ialign) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
    end
  end

endmodule

// File: tb/tb_wide_to_pixel_unpacker.sv
module tb_wide_to_pixel_unpacker;

  logic         clock;
  logic         rst_n;
  logic         ialign;
  logic         i_valid;
  logic         i_ready;
  logic         i_last;
  logic [255:0] idata;
  logic         o_valid;
  logic         o_ready;
  logic [23:0]  o_data;
  logic [2:0]   o_mask;
  logic         o_last;

  logic         m_i_valid;
  logic         m_i_ready;
  logic         m_i_last;
  logic [63:0]  m_idata;
  logic         m_o_valid;
  logic         m_o_ready;
  logic [15:0]  m_o_data;
  logic [1:0]   m_o_mask;
  logic         m_o_last;

  wide_to_pixel_unpacker #(.ISIZE(256), .OSIZE(24), .MSB_FIRST(0)) dut (
    .clock(clock), .rst_n(rst_n), .ialign(ialign),
    .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last), .idata(idata),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_mask(o_mask),
    .o_last(o_last)
  );

  wide_to_pixel_unpacker #(.ISIZE(64), .OSIZE(16), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .rst_n(rst_n), .ialign(ialign),
    .i_valid(m_i_valid), .i_ready(m_i_ready), .i_last(m_i_last), .idata(m_idata),
    .o_valid(m_o_valid), .o_ready(m_o_ready), .o_data(m_o_data), .o_mask(m_o_mask),
    .o_last(m_o_last)
  );

  typedef struct {
    logic [23:0] data;
    logic [2:0]  mask;
    logic        last;
  } pix_t;

  bit   bq[$];      // reference bit stream, oldest first
  pix_t pq[$];      // expected pixels
  pix_t fired[$];   // pixels actually consumed
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_fire   = 0;
  int   cyc      = 0;
  int   first_fire_cyc, last_fire_cyc;
  logic rdy_mode = 1'b0;
  logic hold;
  logic [23:0] hold_data;
  logic [2:0]  hold_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the word is a stream of bits, LSB first; pixels are taken
  // 24 bits at a time; a line end flushes leftovers as a masked pixel.
  task automatic model_accept(input logic [255:0] w, input logic last);
    pix_t p;
    int   n;
    for (int i = 0; i < 256; i++) bq.push_back(w[i]);
    while (bq.size() >= 24) begin
      p.data = '0;
      for (int j = 0; j < 24; j++) p.data[j] = bq.pop_front();
      p.mask = 3'b111;
      p.last = 1'b0;
      pq.push_back(p);
    end
    if (last) begin
      if (bq.size() > 0) begin
        n = bq.size();
        p.data = '0;
        for (int j = 0; j < n; j++) p.data[j] = bq.pop_front();
        p.mask = 3'((1 << ((n + 7) / 8)) - 1);
        p.last = 1'b1;
        pq.push_back(p);
      end else begin
        pq[pq.size()-1].last = 1'b1;
      end
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    o_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares every valid pixel with the reference and logs fires.
  initial begin
    hold = 1'b0;
    forever begin
      pix_t a;
      @(negedge clock);
      if (!rst_n || ialign) begin
        bq.delete();
        pq.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(o_valid), 64'd1);
          check("hold_data", 64'(o_data), 64'(hold_data));
          check("hold_mask", 64'(o_mask), 64'(hold_mask));
        end
        if (o_valid) begin
          if (pq.size() == 0) begin
            check("unexpected_valid", 64'(o_valid), 64'd0);
          end else begin
            check("pix_data", 64'(o_data), 64'(pq[0].data));
            check("pix_mask", 64'(o_mask), 64'(pq[0].mask));
            check("pix_last", 64'(o_last), 64'(pq[0].last));
          end
          if (o_ready) begin
            if (pq.size() > 0) void'(pq.pop_front());
            a.data = o_data;
            a.mask = o_mask;
            a.last = o_last;
            fired.push_back(a);
            if (n_fire == 0) first_fire_cyc = cyc;
            last_fire_cyc = cyc;
            n_fire++;
          end
        end
        hold      = o_valid && !o_ready;
        hold_data = o_data;
        hold_mask = o_mask;
        if (i_valid && i_ready) model_accept(idata, i_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [255:0] w, input logic last);
    logic acc;
    acc     = 1'b0;
    i_valid = 1'b1;
    idata   = w;
    i_last  = last;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(negedge clock);
      acc = i_ready;
      @(posedge clock);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("word_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_fires(input int target);
    for (int k = 0; k < 400 && n_fire < target; k++) begin
      @(posedge clock);
      #1;
    end
    check("fire_count", 64'(n_fire), 64'(target));
  endtask

  task automatic pulse_align();
    ialign = 1'b1;
    @(posedge clock);
    #1;
    ialign = 1'b0;
  endtask

  logic [255:0] w0, w1, w2, wr;
  logic [15:0]  mgot[4];
  logic         mlast[4];
  int           mcnt;

  initial begin
    rst_n = 1'b0; ialign = 1'b0; i_valid = 1'b0; i_last = 1'b0; idata = '0;
    m_i_valid = 1'b0; m_i_last = 1'b0; m_idata = '0; m_o_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_o_mask", 64'(o_mask), 64'd0);
    check("rst_o_last", 64'(o_last), 64'd0);
    check("rst_i_ready", 64'(i_ready), 64'd1);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // Three back-to-back words, no line end, full-rate output.
    for (int k = 0; k < 8; k++) begin
      w0[k*32 +: 32] = $urandom();
      w1[k*32 +: 32] = $urandom();
      w2[k*32 +: 32] = $urandom();
    end
    fired.delete();
    n_fire = 0;
    send_word(w0, 1'b0);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    wait_fires(32);
    repeat (3) begin @(posedge clock); #1; end
    check("b2b_fire_total", 64'(n_fire), 64'd32);
    check("b2b_consecutive", 64'(last_fire_cyc - first_fire_cyc), 64'd31);
    check("b2b_pixel10", 64'(fired[10].data), 64'({w1[7:0], w0[255:240]}));
    @(negedge clock);
    check("b2b_empty_valid", 64'(o_valid), 64'd0);
    check("b2b_empty_ready", 64'(i_ready), 64'd1);
    @(posedge clock); #1;

    // Single line-ending word: 10 full pixels plus a 16-bit partial pixel.
    fired.delete();
    send_word({4{64'h0123_4567_89AB_CDEF}}, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (o_valid && o_ready && o_last) break;
      check("last_ready_low", 64'(i_ready), 64'd0);
    end
    @(posedge clock); #1;
    for (int k = 0; k < 20 && fired.size() < 11; k++) begin @(posedge clock); #1; end
    check("last_pix_count", 64'(fired.size()), 64'd11);
    if (fired.size() == 11) begin
      check("last_full_mask", 64'(fired[9].mask), 64'h7);
      check("last_full_last", 64'(fired[9].last), 64'd0);
      check("last_part_mask", 64'(fired[10].mask), 64'h3);
      check("last_part_data", 64'(fired[10].data), 64'h000123);
      check("last_part_last", 64'(fired[10].last), 64'd1);
    end

    // Random backpressure, line end every sixth word.
    rdy_mode = 1'b1;
    for (int w = 0; w < 64; w++) begin
      for (int k = 0; k < 8; k++) wr[k*32 +: 32] = $urandom();
      send_word(wr, 1'((w % 6) == 5));
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    rdy_mode = 1'b0;
    for (int k = 0; k < 400 && pq.size() != 0; k++) begin @(posedge clock); #1; end
    check("rand_drained", 64'(pq.size()), 64'd0);

    // Realign in the middle of a word.
    pulse_align();
    for (int k = 0; k < 8; k++) w0[k*32 +: 32] = $urandom();
    for (int k = 0; k < 8; k++) w1[k*32 +: 32] = $urandom();
    send_word(w0, 1'b0);
    wait_fires(n_fire + 4);
    pulse_align();
    @(negedge clock);
    check("align_o_valid", 64'(o_valid), 64'd0);
    check("align_i_ready", 64'(i_ready), 64'd1);
    @(posedge clock); #1;
    send_word(w1, 1'b0);
    for (int k = 0; k < 10 && !o_valid; k++) begin @(posedge clock); #1; end
    @(negedge clock);
    check("align_restart", 64'(o_data), 64'(w1[23:0]));
    @(posedge clock); #1;

    // MSB-first instance, 64-bit words into 16-bit pixels.
    m_idata   = 64'hAAAA_BBBB_CCCC_DDDD;
    m_i_last  = 1'b1;
    m_i_valid = 1'b1;
    @(negedge clock);
    check("msb_i_ready", 64'(m_i_ready), 64'd1);
    @(posedge clock); #1;
    m_i_valid = 1'b0;
    m_i_last  = 1'b0;
    mcnt = 0;
    for (int k = 0; k < 20 && mcnt < 4; k++) begin
      @(negedge clock);
      if (m_o_valid && m_o_ready) begin
        mgot[mcnt]  = m_o_data;
        mlast[mcnt] = m_o_last;
        check("msb_mask", 64'(m_o_mask), 64'h3);
        mcnt++;
      end
    end
    check("msb_count", 64'(mcnt), 64'd4);
    if (mcnt == 4) begin
      check("msb_pix0", 64'(mgot[0]), 64'hAAAA);
      check("msb_pix1", 64'(mgot[1]), 64'hBBBB);
      check("msb_pix2", 64'(mgot[2]), 64'hCCCC);
      check("msb_pix3", 64'(mgot[3]), 64'hDDDD);
      check("msb_last2", 64'(mlast[2]), 64'd0);
      check("msb_last3", 64'(mlast[3]), 64'd1);
    end
    @(posedge clock); #1;

    // Asynchronous reset in the middle of a line.
    for (int k = 0; k < 8; k++) w2[k*32 +: 32] = $urandom();
    send_word(w2, 1'b0);
    wait_fires(n_fire + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 64'(o_valid), 64'd0);
    check("arst_o_data", 64'(o_data), 64'd0);
    check("arst_o_mask", 64'(o_mask), 64'd0);
    check("arst_o_last", 64'(o_last), 64'd0);
    @(posedge clock); #2;
    rst_n = 1'b1;
    @(negedge clock);
    check("arst_i_ready", 64'(i_ready), 64'd1);
    check("arst_valid_after", 64'(o_valid), 64'd0);
    @(posedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
